lsm: RTL and testbench

LSM -- requirements
Module: lsm

---
 rtl/ecap5_dproc_pkg.sv | 17 +
 rtl/lsm.sv | 156 +++++++++++++++
 tb/tb_lsm.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecap5_dproc_pkg.sv
// Shared types for the data-processor load/store stage: FSM states and
// access-size encodings used on sel_i.
package ecap5_dproc_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    LSM_IDLE     = 2'd0,
    LSM_REQUEST  = 2'd1,
    LSM_WAIT_ACK = 2'd2
  } lsm_state_t;

  localparam logic [3:0] LS_SIZE_BYTE = 4'b0001;
  localparam logic [3:0] LS_SIZE_HALF = 4'b0011;
  localparam logic [3:0] LS_SIZE_WORD = 4'b1111;

endpackage

// File: rtl/lsm.sv
// Load/store stage: forwards non-memory results and runs one pipelined
// Wishbone B4 transaction per memory instruction, aligning and extending loads.
module lsm
  import ecap5_dproc_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                input_ready_o,
  input  logic                input_valid_i,
  input  logic [DATA_W-1:0]   alu_result_i,
  input  logic                enable_i,
  input  logic                write_i,
  input  logic                unsigned_load_i,
  input  logic [DATA_W-1:0]   write_data_i,
  input  logic [3:0]          sel_i,
  input  logic                reg_write_i,
  input  logic [4:0]          reg_addr_i,
  output logic                output_valid_o,
  output logic                reg_write_o,
  output logic [4:0]          reg_addr_o,
  output logic [DATA_W-1:0]   reg_data_o,
  output logic [DATA_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [3:0]          wb_sel_o,
  output logic                wb_we_o,
  output logic                wb_stb_o,
  output logic                wb_cyc_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_stall_i
);

  function automatic logic [DATA_W-1:0] align_load(
    input logic [DATA_W-1:0] data,
    input logic [1:0]        ofs,
    input logic [3:0]        size,
    input logic              uns
  );
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] res;
    sh = data >> {ofs, 3'b000};
    case (size)
      LS_SIZE_BYTE: res = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      LS_SIZE_HALF: res = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default:      res = data;
    endcase
    return res;
  endfunction

  lsm_state_t state_q, state_d;
  logic       accept;
  logic       complete;

  logic [1:0] addr_lo_p0;
  logic [3:0] size_p0;
  logic       uns_p0;
  logic       store_p0;
  logic       rw_p0;

  assign input_ready_o = (state_q == LSM_IDLE);

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      LSM_IDLE: begin
        if (input_valid_i) begin
          accept = 1'b1;
          if (enable_i) state_d = LSM_REQUEST;
        end
      end
      LSM_REQUEST: begin
        // ack is only meaningful once the strobe has been taken by the slave
        if (!wb_stall_i) begin
          if (wb_ack_i) begin
            complete = 1'b1;
            state_d  = LSM_IDLE;
          end else begin
            state_d  = LSM_WAIT_ACK;
          end
        end
      end
      LSM_WAIT_ACK: begin
        if (wb_ack_i) begin
          complete = 1'b1;
          state_d  = LSM_IDLE;
        end
      end
      default: state_d = LSM_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= LSM_IDLE;
    else       state_q <= state_d;
  end

  // stage p0 -> p1: handshake and bus control
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      output_valid_o <= 1'b0;
      reg_write_o    <= 1'b0;
      wb_cyc_o       <= 1'b0;
      wb_stb_o       <= 1'b0;
    end else begin
      output_valid_o <= (accept && !enable_i) || complete;
      reg_write_o    <= (accept && !enable_i && reg_write_i) || (complete && rw_p0);
      if (accept && enable_i) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
      end else if (state_q == LSM_REQUEST && !wb_stall_i) begin
        wb_stb_o <= 1'b0;
        if (wb_ack_i) wb_cyc_o <= 1'b0;
      end else if (state_q == LSM_WAIT_ACK && wb_ack_i) begin
        wb_cyc_o <= 1'b0;
      end
    end
  end

  // visible bus/write-back data is cleared on reset so idle outputs are deterministic
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_addr_o <= '0;
      reg_data_o <= '0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= '0;
      wb_we_o    <= 1'b0;
    end else begin
      if (accept) begin
        reg_addr_o <= reg_addr_i;
        reg_data_o <= alu_result_i;
        if (enable_i) begin
          wb_adr_o <= {alu_result_i[DATA_W-1:2], 2'b00};
          wb_dat_o <= write_data_i << {alu_result_i[1:0], 3'b000};
          wb_sel_o <= sel_i << alu_result_i[1:0];
          wb_we_o  <= write_i;
        end
      end else if (complete && !store_p0) begin
        reg_data_o <= align_load(wb_dat_i, addr_lo_p0, size_p0, uns_p0);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      rw_p0      <= reg_write_i;
      addr_lo_p0 <= alu_result_i[1:0];
      size_p0    <= sel_i;
      uns_p0     <= unsigned_load_i;
      store_p0   <= write_i;
    end
  end

endmodule

// File: tb/tb_lsm.sv
// Scoreboard bench for the load/store stage: expected write-backs are queued
// at issue time and compared whenever output_valid_o is seen.
module tb_lsm;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        input_ready_o;
  logic        input_valid_i;
  logic [31:0] alu_result_i;
  logic        enable_i, write_i, unsigned_load_i;
  logic [31:0] write_data_i;
  logic [3:0]  sel_i;
  logic        reg_write_i;
  logic [4:0]  reg_addr_i;
  logic        output_valid_o, reg_write_o;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_stall_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic [4:0]  ra;
    logic [31:0] data;
  } wb_exp_t;
  wb_exp_t sb[$];

  lsm dut (
    .clk_i(clk_i), .rst_i(rst_i), .input_ready_o(input_ready_o),
    .input_valid_i(input_valid_i), .alu_result_i(alu_result_i),
    .enable_i(enable_i), .write_i(write_i), .unsigned_load_i(unsigned_load_i),
    .write_data_i(write_data_i), .sel_i(sel_i), .reg_write_i(reg_write_i),
    .reg_addr_i(reg_addr_i), .output_valid_o(output_valid_o),
    .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (!rst_i && output_valid_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: output_valid_o=1 with nothing expected, reg_data_o=%h", reg_data_o);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        if (reg_write_o !== e.rw || reg_addr_o !== e.ra || reg_data_o !== e.data) begin
          errors++;
          $display("FAIL writeback: got rw=%b ra=%0d data=%h, expected rw=%b ra=%0d data=%h",
                   reg_write_o, reg_addr_o, reg_data_o, e.rw, e.ra, e.data);
        end
      end
    end
  end

  function automatic logic [3:0] m_sel(input logic [3:0] sel, input logic [1:0] a);
    logic [7:0] w;
    w = {4'b0, sel} << a;
    return w[3:0];
  endfunction

  function automatic logic [31:0] m_wdat(input logic [31:0] d, input logic [1:0] a);
    logic [63:0] w;
    w = {32'b0, d} << (8 * a);
    return w[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] d, input logic [1:0] a,
                                         input logic [3:0] sel, input logic uns);
    logic [63:0] e;
    logic [15:0] seg;
    e   = {32'b0, d};
    seg = e[8*a +: 16];
    case (sel)
      4'b0001: return uns ? {24'b0, seg[7:0]} : {{24{seg[7]}}, seg[7:0]};
      4'b0011: return uns ? {16'b0, seg} : {{16{seg[15]}}, seg};
      default: return d;
    endcase
  endfunction

  task automatic drive(input logic [31:0] alu, input logic en, input logic we,
                       input logic uns, input logic [31:0] wd, input logic [3:0] sel,
                       input logic rw, input logic [4:0] ra);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!input_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL ready_timeout: input_ready_o=%b, expected 1 within 100 cycles", input_ready_o);
    end
    input_valid_i = 1'b1; alu_result_i = alu; enable_i = en; write_i = we;
    unsigned_load_i = uns; write_data_i = wd; sel_i = sel; reg_write_i = rw; reg_addr_i = ra;
    @(posedge clk_i); #1;
    input_valid_i = 1'b0;
  endtask

  task automatic mem_op(input logic [31:0] addr, input logic we, input logic uns,
                        input logic [3:0] sel, input logic [31:0] wd, input logic [31:0] rd,
                        input int stall, input int ack_dly, input logic rw, input logic [4:0] ra,
                        input logic [3:0] exp_sel, input logic [31:0] exp_wdat,
                        input logic [31:0] exp_data);
    wb_exp_t e;
    e.rw = rw; e.ra = ra; e.data = exp_data;
    sb.push_back(e);
    wb_ack_i = 1'b0; wb_stall_i = 1'b0;
    drive(addr, 1'b1, we, uns, wd, sel, rw, ra);
    checks++;
    if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || wb_adr_o !== {addr[31:2], 2'b00} ||
        wb_sel_o !== exp_sel || wb_we_o !== we || (we && wb_dat_o !== exp_wdat) || input_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL request: cyc=%b stb=%b adr=%h sel=%b we=%b dat=%h rdy=%b, expected 1 1 %h %b %b %h 0",
               wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o, input_ready_o,
               {addr[31:2], 2'b00}, exp_sel, we, exp_wdat);
    end
    for (int i = 0; i < stall; i++) begin
      wb_stall_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
      @(posedge clk_i); #1;
      checks++;
      if (wb_stb_o !== 1'b1 || wb_cyc_o !== 1'b1 || wb_sel_o !== exp_sel ||
          input_ready_o !== 1'b0 || output_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: stb=%b cyc=%b sel=%b rdy=%b vld=%b, expected 1 1 %b 0 0",
                 wb_stb_o, wb_cyc_o, wb_sel_o, input_ready_o, output_valid_o, exp_sel);
      end
    end
    wb_stall_i = 1'b0; wb_ack_i = (ack_dly == 0); wb_dat_i = rd;
    @(posedge clk_i); #1;
    wb_ack_i = 1'b0;
    if (ack_dly == 0) begin
      checks++;
      if (output_valid_o !== 1'b1 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
        errors++;
        $display("FAIL zero_wait: vld=%b cyc=%b stb=%b, expected 1 0 0", output_valid_o, wb_cyc_o, wb_stb_o);
      end
    end else begin
      checks++;
      if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b1 || output_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL wait_ack_entry: stb=%b cyc=%b vld=%b, expected 0 1 0", wb_stb_o, wb_cyc_o, output_valid_o);
      end
      for (int i = 1; i < ack_dly; i++) begin
        @(posedge clk_i); #1;
        checks++;
        if (wb_cyc_o !== 1'b1 || output_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL wait_ack_hold: cyc=%b vld=%b, expected 1 0", wb_cyc_o, output_valid_o);
        end
      end
      wb_ack_i = 1'b1;
      @(posedge clk_i); #1;
      wb_ack_i = 1'b0;
      checks++;
      if (output_valid_o !== 1'b1 || wb_cyc_o !== 1'b0) begin
        errors++;
        $display("FAIL ack_done: vld=%b cyc=%b, expected 1 0", output_valid_o, wb_cyc_o);
      end
    end
    @(posedge clk_i); #1;
    checks++;
    if (output_valid_o !== 1'b0 || input_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL single_pulse: vld=%b rdy=%b, expected 0 1", output_valid_o, input_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; input_valid_i = 1'b0; alu_result_i = '0; enable_i = 1'b0; write_i = 1'b0;
    unsigned_load_i = 1'b0; write_data_i = '0; sel_i = '0; reg_write_i = 1'b0; reg_addr_i = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_stall_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (output_valid_o !== 1'b0 || reg_write_o !== 1'b0 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 ||
        wb_we_o !== 1'b0 || wb_sel_o !== 4'b0 || input_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: vld=%b rw=%b cyc=%b stb=%b we=%b sel=%b rdy=%b, expected 0 0 0 0 0 0000 1",
               output_valid_o, reg_write_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, input_ready_o);
    end
    checks++;
    if (reg_addr_o !== 5'd0 || reg_data_o !== 32'd0 || wb_adr_o !== 32'd0 || wb_dat_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: ra=%0d rd=%h adr=%h dat=%h, expected all 0",
               reg_addr_o, reg_data_o, wb_adr_o, wb_dat_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_non_memory();
    wb_exp_t e;
    e.rw = 1'b1; e.ra = 5'd5; e.data = 32'h0000_1234;
    sb.push_back(e);
    drive(32'h1234, 1'b0, 1'b0, 1'b0, 32'h0, 4'b1111, 1'b1, 5'd5);
    checks++;
    if (output_valid_o !== 1'b1 || reg_write_o !== 1'b1 || wb_stb_o !== 1'b0 ||
        wb_cyc_o !== 1'b0 || input_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL non_memory: vld=%b rw=%b stb=%b cyc=%b rdy=%b, expected 1 1 0 0 1",
               output_valid_o, reg_write_o, wb_stb_o, wb_cyc_o, input_ready_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (output_valid_o !== 1'b0 || reg_write_o !== 1'b0) begin
      errors++;
      $display("FAIL non_memory_pulse: vld=%b rw=%b, expected 0 0", output_valid_o, reg_write_o);
    end
  endtask

  task automatic test_byte_load();
    mem_op(32'h1003, 1'b0, 1'b0, 4'b0001, 32'h0, 32'h80AA_BBCC, 0, 0, 1'b1, 5'd3,
           4'b1000, 32'h0, 32'hFFFF_FF80);
    mem_op(32'h1003, 1'b0, 1'b1, 4'b0001, 32'h0, 32'h80AA_BBCC, 0, 0, 1'b1, 5'd4,
           4'b1000, 32'h0, 32'h0000_0080);
  endtask

  task automatic test_half_store_stall();
    mem_op(32'h2002, 1'b1, 1'b0, 4'b0011, 32'h0000_BEEF, 32'h0, 3, 1, 1'b0, 5'd7,
           4'b1100, 32'hBEEF_0000, 32'h0000_2002);
  endtask

  task automatic test_word_load_delayed();
    mem_op(32'h3000, 1'b0, 1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D, 0, 5, 1'b1, 5'd9,
           4'b1111, 32'h0, 32'hCAFE_F00D);
  endtask

  task automatic test_reset_in_wait_ack();
    wb_ack_i = 1'b0; wb_stall_i = 1'b0;
    drive(32'h4000, 1'b1, 1'b0, 1'b0, 32'h0, 4'b1111, 1'b1, 5'd1);
    @(posedge clk_i); #1;
    checks++;
    if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_setup: cyc=%b stb=%b, expected 1 0", wb_cyc_o, wb_stb_o);
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h1111_2222;
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || input_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_abandon: cyc=%b stb=%b rdy=%b, expected 0 0 1", wb_cyc_o, wb_stb_o, input_ready_o);
    end
    @(posedge clk_i); #1;
    wb_ack_i = 1'b0;
    checks++;
    if (output_valid_o !== 1'b0 || wb_cyc_o !== 1'b0 || input_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_late_ack: vld=%b cyc=%b rdy=%b, expected 0 0 1", output_valid_o, wb_cyc_o, input_ready_o);
    end
  endtask

  task automatic test_spurious_ack();
    wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (output_valid_o !== 1'b0 || input_ready_o !== 1'b1 || wb_cyc_o !== 1'b0) begin
        errors++;
        $display("FAIL spurious_ack: vld=%b rdy=%b cyc=%b, expected 0 1 0", output_valid_o, input_ready_o, wb_cyc_o);
      end
    end
    wb_ack_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, rd;
    logic [3:0]  sz;
    logic        u;
    wb_exp_t     e;
    for (int i = 0; i < 8; i++) begin
      a  = $urandom;
      rd = $urandom;
      u  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: sz = 4'b0001;
        1: sz = 4'b0011;
        default: begin sz = 4'b1111; a[1:0] = 2'b00; end
      endcase
      mem_op(a, 1'b0, u, sz, 32'h0, rd, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1,
             5'(i + 10), m_sel(sz, a[1:0]), 32'h0, m_load(rd, a[1:0], sz, u));
      e.rw = 1'b0; e.ra = 5'(i); e.data = rd ^ a;
      sb.push_back(e);
      drive(rd ^ a, 1'b0, 1'b0, 1'b0, 32'h0, 4'b1111, 1'b0, 5'(i));
    end
    a = 32'h0000_5001;
    rd = 32'hA1B2_C3D4;
    mem_op(a, 1'b1, 1'b0, 4'b0011, rd, 32'h0, 1, 0, 1'b0, 5'd2,
           m_sel(4'b0011, a[1:0]), m_wdat(rd, a[1:0]), a);
  endtask

  initial begin
    test_reset();
    test_non_memory();
    test_byte_load();
    test_half_store_stall();
    test_word_load_delayed();
    test_reset_in_wait_ack();
    test_spurious_ack();
    test_back_to_back();
    repeat (4) @(posedge clk_i);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d outstanding, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
